// File: rtl/pll_reset_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer slice:
//   pll_state_e   - sequencer states, with fixed encodings visible on state_dbg
//   SYNC_STAGES   - depth of the async-input synchronizer
//   holds_pll_rst - states in which the PLL must be held in reset
// ----------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int SYNC_STAGES = 2;

  // The PLL reset pin is asserted in the reset phase and while parked in fault.
  function automatic logic holds_pll_rst(input pll_state_e st);
    return (st == ST_RESET) || (st == ST_FAULT);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer_if
// Groups the sequencer's control/status signals. The sequencer uses the
// slave modport; whoever drives restart/pll_locked uses master.
//   restart    - one-cycle synchronous restart request (into sequencer)
//   pll_locked - raw, asynchronous PLL lock flag (into sequencer)
//   pll_rst    - active-high PLL reset
//   clk_ready  - PLL clock qualified stable
//   fault      - sticky retry-exhaustion flag
//   retry_cnt  - failed attempts since last RUN entry or restart
//   state_dbg  - encoded sequencer state
//   loss_cnt   - RUN lock-loss counter (only with PLL_SEQ_LOSS_CNT_EN)
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN
// ----------------------------------------------------------------------------
interface pll_reset_sequencer_if #(
  parameter int RETRY_W = 4
);
  logic               restart;
  logic               pll_locked;
  logic               pll_rst;
  logic               clk_ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state_dbg;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [15:0]        loss_cnt;

  modport slave (
    input  restart, pll_locked,
    output pll_rst, clk_ready, fault, retry_cnt, state_dbg, loss_cnt
  );

  modport master (
    output restart, pll_locked,
    input  pll_rst, clk_ready, fault, retry_cnt, state_dbg, loss_cnt
  );
`else
  modport slave (
    input  restart, pll_locked,
    output pll_rst, clk_ready, fault, retry_cnt, state_dbg
  );

  modport master (
    output restart, pll_locked,
    input  pll_rst, clk_ready, fault, retry_cnt, state_dbg
  );
`endif

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Generic single-bit synchronizer for asynchronous inputs (PLL lock, camera
// and UART async lines). Output is delayed by SYNC_STAGES clk edges.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (flops clear to 0)
//   d_i   - asynchronous input
//   q_o   - synchronized output
// ----------------------------------------------------------------------------
module sync_2ff
  import pll_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the async input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
// Drives the 24 MHz PLL reset from the 50 MHz reference, qualifies lock for
// STABLE_CYCLES before raising clk_ready, re-resets on lock loss or lock
// timeout, and parks in a sticky fault after MAX_RETRIES failed attempts.
//   refclk - reference clock, sole clock of the block
//   rst_n  - asynchronous active-low reset (pll_rst goes high immediately)
//   bus    - pll_reset_sequencer_if.slave: restart, pll_locked in;
//            pll_rst, clk_ready, fault, retry_cnt, state_dbg (and loss_cnt) out
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN adds loss_cnt, a saturating
// count of lock losses seen while in RUN, cleared only by rst_n.
// ----------------------------------------------------------------------------
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 20,
  parameter int RETRY_W       = 4
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_ZERO  = {RETRY_W{1'b0}};
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  pll_state_e         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [RETRY_W-1:0] retry_q,  retry_d;
  logic               pll_rst_q;
  logic               clk_ready_q;
  logic               fault_q;
  pll_state_e         fail_state_s;
  logic [RETRY_W-1:0] fail_retry_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (bus.pll_locked),
    .q_o   (lock_s)
  );

  // Where a failure event (timeout or RUN lock loss) would send us.
  always_comb begin
    fail_state_s = ST_RESET;
    fail_retry_s = retry_q;
    if (retry_q == RETRY_MAX) begin
      fail_state_s = ST_FAULT;
      fail_retry_s = retry_q;
    end else begin
      fail_state_s = ST_RESET;
      fail_retry_s = (&retry_q) ? retry_q : (retry_q + RETRY_ONE);
    end
  end

  // Next-state logic; restart overrides every other event in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    retry_d = retry_q;
    if (bus.restart) begin
      state_d = ST_RESET;
      cnt_d   = CNT_ZERO;
      retry_d = RETRY_ZERO;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_RESET;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = fail_state_s;
            retry_d = fail_retry_s;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          // A drop here is an acquisition glitch: restart the timeout window
          // without charging a retry.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
            retry_d = RETRY_ZERO;
          end else begin
            state_d = ST_STABLE;
          end
        end
        ST_RUN: begin
          cnt_d = CNT_ZERO;
          if (!lock_s) begin
            state_d = fail_state_s;
            retry_d = fail_retry_s;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
          cnt_d   = CNT_ZERO;
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Sequencer registers; outputs are decoded from the next state so they
  // change on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= CNT_ZERO;
      retry_q     <= RETRY_ZERO;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= holds_pll_rst(state_d);
      clk_ready_q <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.clk_ready = clk_ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_dbg = state_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [15:0] loss_q;
  logic        loss_evt_s;

  // A restart in the same cycle pre-empts the lock-loss event.
  assign loss_evt_s = (state_q == ST_RUN) && !lock_s && !bus.restart;

  // Saturating lifetime lock-loss counter, cleared only by rst_n.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 16'h0000;
    end else if (loss_evt_s && (loss_q != 16'hFFFF)) begin
      loss_q <= loss_q + 16'h0001;
    end else begin
      loss_q <= loss_q;
    end
  end

  assign bus.loss_cnt = loss_q;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Control stage wrapped around the 24 MHz camera/UART PLL, clocked by the 50 MHz board reference.
- Drives the PLL's active-high reset and consumes the PLL's asynchronous lock output.
- Releases a qualified "clock ready" only after lock has been stable for a programmable time.
- Re-resets the PLL on lock loss or acquisition timeout, and enters a sticky fault state after too many retries.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (≥2)
LOCK_TIMEOUT, 50000, refclk cycles allowed for lock after pll_rst release (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before clk_ready
MAX_RETRIES, 3, failed attempts tolerated before FAULT
CNT_W, 20, width of the shared phase counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)
RETRY_W, 4, width of retry_cnt

Ports:
refclk  in  1  50 MHz reference clock; sole clock of the block
rst_n  in  1  asynchronous active-low reset
restart  in  1  synchronous one-cycle request: restart the sequence and clear retries
pll_locked  in  1  PLL lock flag; asynchronous to refclk
pll_rst  out  1  active-high reset to the PLL
clk_ready  out  1  PLL output qualified stable; downstream reset release
fault  out  1  sticky: retries exhausted
retry_cnt  out  RETRY_W  failed attempts since last RUN entry or restart; saturating
state_dbg  out  3  encoded FSM state for debug/LED

Behaviour:
- Reset values (rst_n low, asynchronous): pll_rst=1, clk_ready=0, fault=0, retry_cnt=0, state=RESET, counter=0, sync flops=0.
- Lock synchronizer: pll_locked passes through 2 refclk flops to form lock_s (2-cycle latency). All decisions use lock_s only.
- All outputs are registered. State encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- RESET:
  - pll_rst=1; counter increments.
  - At counter==RST_CYCLES-1: clear counter, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0; counter increments.
  - If lock_s=1: clear counter, go to STABLE.
  - Else at counter==LOCK_TIMEOUT-1: failure event.
- STABLE:
  - If lock_s=0: go to WAIT_LOCK with counter cleared. Lock-acquisition glitch; no failure counted, timeout window restarts.
  - At counter==STABLE_CYCLES-1 with lock_s=1: go to RUN, clk_ready=1 from the same edge, retry_cnt cleared.
- RUN:
  - clk_ready=1.
  - If lock_s=0: clk_ready=0 at the next edge, and a failure event occurs.
- Failure event:
  - If retry_cnt==MAX_RETRIES: go to FAULT.
  - Else: retry_cnt+1 (saturates at all-ones), go to RESET, counter cleared.
- FAULT: pll_rst=1, fault=1, clk_ready=0; held until restart or rst_n.
- restart (any state):
  - Go to RESET, counter=0, retry_cnt=0, fault=0, clk_ready=0 at the next edge.
  - Has priority over every simultaneous event, including lock loss and timeout.
- Counter has a single owner, the FSM; it is cleared on every state transition.
- rst_n asserted mid-sequence: immediate return to reset values; pll_rst goes high asynchronously.
- pll_locked toggling while in RESET or FAULT is ignored.

Optional Feature:
PLL_SEQ_LOSS_CNT_EN
- Defined:
  - Adds output loss_cnt [15:0], counting RUN→lock-loss events.
  - Saturates at 16'hFFFF.
  - Cleared only by rst_n; not by restart or RUN entry.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum typedef, with the fixed encodings above;
  - the SYNC_STAGES=2 constant.
- Natural sub-module: sync_2ff, a generic single-bit 2-flop synchronizer with async active-low reset. Reusable for the camera and UART async inputs.

Test Plan:
1. Release rst_n; pll_locked rises 100 cycles after pll_rst falls and stays high. Required: pll_rst high for exactly 16 cycles; clk_ready rises 1024+2 cycles after lock; retry_cnt=0.
2. pll_locked never rises. Required:
   - three timeouts of 50000 cycles, each followed by a 16-cycle pll_rst pulse;
   - retry_cnt reaches 3;
   - fourth timeout gives fault=1 with pll_rst held high.
3. In RUN, drop pll_locked for one cycle. Required: clk_ready falls 3 edges later, retry_cnt=1, new 16-cycle pll_rst pulse, then relock gives RUN with retry_cnt=0.
4. In STABLE, glitch pll_locked low at counter 500. Required: back to WAIT_LOCK, no retry increment, clk_ready only after a full 1024 fresh stable cycles.
5. In FAULT, pulse restart coincident with pll_locked rising. Required: fault=0, retry_cnt=0, state RESET next edge, normal sequence follows.
6. With PLL_SEQ_LOSS_CNT_EN defined: 5 lock losses in RUN followed by a restart. Required: loss_cnt=5, unchanged by the restart; assert rst_n low gives loss_cnt=0.
